// File: rtl/mpe_fmap_feeder_if.sv
// Buffer-to-column bundle for mpe_fmap_feeder: weight/fmap valid-ready inputs plus
// the per-PE weight, fmap and enable outputs toward one PE column.
interface mpe_fmap_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUMBER_PE  = 9
);
  localparam int VW = DATA_WIDTH * NUMBER_PE;

  logic                 w_valid;
  logic                 w_ready;
  logic [VW-1:0]        w_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [VW-1:0]        s_data;
  logic                 s_last;
  logic [VW-1:0]        weight_out;
  logic                 weight_en;
  logic [VW-1:0]        fmap_out;
  logic [NUMBER_PE-1:0] left_en;
  logic [NUMBER_PE-1:0] right_en;
  logic                 busy;
  logic                 done;

  modport master (
    output w_valid, w_data, s_valid, s_data, s_last,
    input  w_ready, s_ready, weight_out, weight_en, fmap_out, left_en, right_en, busy, done
  );

  modport slave (
    input  w_valid, w_data, s_valid, s_data, s_last,
    output w_ready, s_ready, weight_out, weight_en, fmap_out, left_en, right_en, busy, done
  );
endinterface

// File: rtl/mpe_fmap_feeder.sv
// Loads weights and skews fmap vectors so lane k hits PE k at accept+1+k*SKEW cycles.
// One vector/cycle in STREAM; ready drops in LOAD_W/DRAIN and while weights are pending.
module mpe_fmap_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int NUMBER_PE  = 9,
  parameter int SKEW       = 1
) (
  input  logic             i_clk,
  input  logic             i_rest_n,
  mpe_fmap_feeder_if.slave bus
);
  localparam int VW    = DATA_WIDTH * NUMBER_PE;
  localparam int DEPTH = (NUMBER_PE - 1) * SKEW + 1;
  localparam int LAST  = (NUMBER_PE - 1) * SKEW + 1;
  localparam int CW    = $clog2(LAST + 1);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 wt_loaded;
  logic [VW-1:0]        weight_q;
  logic [DEPTH-1:0]     pipe_vld;
  logic [VW-1:0]        pipe_dat [DEPTH];
  logic                 w_rdy, s_rdy, w_acc, s_acc;
  logic [NUMBER_PE-1:0] lane_en;
  logic [VW-1:0]        lane_dat;

  // A pending weight vector blocks fmap acceptance in IDLE so weights win ties.
  assign w_rdy = !i_rest_n || (state_q == IDLE);
  assign s_rdy = i_rest_n && ((state_q == STREAM) ||
                              ((state_q == IDLE) && wt_loaded && !bus.w_valid));
  assign w_acc = i_rest_n && (state_q == IDLE) && bus.w_valid;
  assign s_acc = s_rdy && bus.s_valid;

  always_ff @(posedge i_clk) begin
    if (!i_rest_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_acc) begin
          state_d = LOAD_W;
        end else if (s_acc) begin
          state_d = bus.s_last ? DRAIN : STREAM;
          cnt_d   = '0;
        end
      end
      LOAD_W: state_d = STREAM;
      STREAM: begin
        if (s_acc && bus.s_last) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        // Count covers the last lane's delay plus the done cycle itself.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage data only advances with a valid so every tap holds across bubbles.
  always_ff @(posedge i_clk) begin
    if (!i_rest_n) begin
      pipe_vld  <= '0;
      weight_q  <= '0;
      wt_loaded <= 1'b0;
      for (int j = 0; j < DEPTH; j++) pipe_dat[j] <= '0;
    end else begin
      pipe_vld[0] <= s_acc;
      if (s_acc) pipe_dat[0] <= bus.s_data;
      for (int j = 1; j < DEPTH; j++) begin
        pipe_vld[j] <= pipe_vld[j-1];
        if (pipe_vld[j-1]) pipe_dat[j] <= pipe_dat[j-1];
      end
      if (w_acc) begin
        weight_q  <= bus.w_data;
        wt_loaded <= 1'b1;
      end
    end
  end

  always_comb begin
    lane_en  = '0;
    lane_dat = '0;
    for (int k = 0; k < NUMBER_PE; k++) begin
      lane_en[k] = pipe_vld[k*SKEW];
      lane_dat[k*DATA_WIDTH +: DATA_WIDTH] = pipe_dat[k*SKEW][k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.w_ready    = w_rdy;
  assign bus.s_ready    = s_rdy;
  assign bus.weight_out = weight_q;
  assign bus.weight_en  = (state_q == LOAD_W);
  assign bus.fmap_out   = lane_dat;
  assign bus.left_en    = lane_en;
  assign bus.right_en   = lane_en;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DRAIN) && (cnt_q == CW'(LAST));
endmodule

// File: tb/tb_mpe_fmap_feeder.sv
// Scoreboard bench for mpe_fmap_feeder: a timeline model predicts per-lane enable events,
// ready/busy windows, weight_en and done; a negedge monitor pops and compares.
module tb_mpe_fmap_feeder;
  localparam int DW  = 32;
  localparam int NP  = 9;
  localparam int SK  = 1;
  localparam int VW  = DW * NP;
  localparam int INF = 1 << 30;

  typedef struct {
    int            c;
    logic [DW-1:0] d;
  } ev_t;

  logic clk;
  logic rst_n;

  mpe_fmap_feeder_if #(.DATA_WIDTH(DW), .NUMBER_PE(NP)) bus ();

  mpe_fmap_feeder #(.DATA_WIDTH(DW), .NUMBER_PE(NP), .SKEW(SK)) dut (
    .i_clk   (clk),
    .i_rest_n(rst_n),
    .bus     (bus)
  );

  ev_t           lane_q [NP][$];
  int            we_q[$];
  int            done_q[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            idle_from, stream_from, drain_from;
  bit            loaded;
  logic [VW-1:0] m_weight;
  logic [DW-1:0] hold [NP];
  bit            m_ee;
  logic [DW-1:0] m_ed;
  bit            d_wa, d_sa;
  ev_t           p_ev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout at cyc=%0d", nm, cyc);
  endtask

  function automatic bit exp_w_ready();
    return !rst_n || (cyc >= idle_from);
  endfunction

  function automatic bit exp_s_ready();
    return rst_n && (((cyc >= stream_from) && (cyc < drain_from)) ||
                     ((cyc >= idle_from) && loaded && !bus.w_valid));
  endfunction

  function automatic logic [DW-1:0] fp_of(input int i);
    case (i)
      1: return 32'h3F80_0000;
      2: return 32'h4000_0000;
      3: return 32'h4040_0000;
      4: return 32'h4080_0000;
      5: return 32'h40A0_0000;
      6: return 32'h40C0_0000;
      7: return 32'h40E0_0000;
      8: return 32'h4100_0000;
      default: return 32'h4110_0000;
    endcase
  endfunction

  function automatic logic [VW-1:0] mkvec(input int base);
    logic [VW-1:0] v;
    for (int k = 0; k < NP; k++) v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  function automatic logic [VW-1:0] rndvec();
    logic [VW-1:0] v;
    for (int k = 0; k < NP; k++) v[k*DW +: DW] = $urandom;
    return v;
  endfunction

  // One bus cycle; acceptance is decided by the model's ready windows, not the DUT's.
  task automatic cyc_drive(input logic wv, input logic [VW-1:0] wd, input logic sv,
                           input logic [VW-1:0] sd, input logic sl, input logic rn,
                           output bit wa, output bit sa);
    int n;
    @(posedge clk);
    #1;
    rst_n       = rn;
    bus.w_valid = wv;
    bus.w_data  = wd;
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.s_last  = sl;
    @(negedge clk);
    #1;
    n  = cyc;
    wa = rn && wv && exp_w_ready();
    sa = rn && sv && exp_s_ready();
    if (!rn) begin
      loaded      = 1'b0;
      m_weight    = '0;
      idle_from   = n + 1;
      stream_from = INF;
      drain_from  = INF;
    end else if (wa) begin
      m_weight    = wd;
      loaded      = 1'b1;
      idle_from   = INF;
      stream_from = n + 2;
      drain_from  = INF;
      we_q.push_back(n + 1);
    end else if (sa) begin
      for (int k = 0; k < NP; k++) begin
        p_ev.c = n + 1 + k * SK;
        p_ev.d = sd[k*DW +: DW];
        lane_q[k].push_back(p_ev);
      end
      if (n >= idle_from) begin
        idle_from   = INF;
        stream_from = n + 1;
        drain_from  = INF;
      end
      if (sl) begin
        drain_from = n + 1;
        idle_from  = n + 3 + (NP - 1) * SK;
        done_q.push_back(n + 2 + (NP - 1) * SK);
      end
    end
  endtask

  task automatic idle_cycle();
    bit wa, sa;
    cyc_drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, wa, sa);
  endtask

  task automatic load_w(input logic [VW-1:0] v);
    bit wa, sa;
    wa = 1'b0;
    for (int i = 0; i < 50 && !wa; i++) cyc_drive(1'b1, v, 1'b0, '0, 1'b0, 1'b1, wa, sa);
    if (!wa) timeout_fail("w_accept");
  endtask

  task automatic send_vec(input logic [VW-1:0] v, input logic l);
    bit wa, sa;
    sa = 1'b0;
    for (int i = 0; i < 50 && !sa; i++) cyc_drive(1'b0, '0, 1'b1, v, l, 1'b1, wa, sa);
    if (!sa) timeout_fail("s_accept");
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((cyc + 1 < idle_from) && (i < 100)) begin
      idle_cycle();
      i++;
    end
    if (i >= 100) timeout_fail("wait_idle");
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        chk("w_ready", VW'(bus.w_ready), VW'(exp_w_ready()));
        chk("s_ready", VW'(bus.s_ready), VW'(exp_s_ready()));
        for (int k = 0; k < NP; k++) begin
          m_ee = (lane_q[k].size() > 0) && (lane_q[k][0].c == cyc);
          m_ed = hold[k];
          if (m_ee) begin
            m_ed    = lane_q[k][0].d;
            hold[k] = m_ed;
            void'(lane_q[k].pop_front());
          end
          chk($sformatf("left_en%0d", k), VW'(bus.left_en[k]), VW'(m_ee));
          chk($sformatf("right_en%0d", k), VW'(bus.right_en[k]), VW'(m_ee));
          chk($sformatf("fmap_lane%0d", k), VW'(bus.fmap_out[k*DW +: DW]), VW'(m_ed));
        end
        m_ee = (we_q.size() > 0) && (we_q[0] == cyc);
        if (m_ee) void'(we_q.pop_front());
        chk("weight_en", VW'(bus.weight_en), VW'(m_ee));
        m_ee = (done_q.size() > 0) && (done_q[0] == cyc);
        if (m_ee) void'(done_q.pop_front());
        chk("done", VW'(bus.done), VW'(m_ee));
        chk("weight_out", bus.weight_out, m_weight);
        chk("busy", VW'(bus.busy), VW'(cyc < idle_from));
        if (!rst_n) begin
          for (int k = 0; k < NP; k++) begin
            lane_q[k].delete();
            hold[k] = '0;
          end
          we_q.delete();
          done_q.delete();
        end
      end
    end
  end

  initial begin : stim
    logic [VW-1:0] wv;
    int            len, tot;
    rst_n       = 1'b0;
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    loaded      = 1'b0;
    m_weight    = '0;
    idle_from   = 0;
    stream_from = INF;
    drain_from  = INF;
    for (int k = 0; k < NP; k++) hold[k] = '0;

    // Reset with a stray fmap valid, then fmap offered before any weights exist.
    repeat (2) cyc_drive(1'b0, '0, 1'b1, mkvec(100), 1'b1, 1'b0, d_wa, d_sa);
    repeat (2) cyc_drive(1'b0, '0, 1'b1, mkvec(100), 1'b1, 1'b1, d_wa, d_sa);

    for (int k = 0; k < NP; k++) wv[k*DW +: DW] = fp_of(k + 1);
    load_w(wv);

    for (int v = 0; v < 3; v++) send_vec(mkvec(10 * v), v == 2);
    wait_idle();

    send_vec(mkvec(50), 1'b0);
    idle_cycle();
    send_vec(mkvec(60), 1'b1);
    wait_idle();

    // Weight and fmap both valid in IDLE with weights already loaded.
    cyc_drive(1'b1, mkvec(200), 1'b1, mkvec(70), 1'b0, 1'b1, d_wa, d_sa);
    if (!d_wa) timeout_fail("tie_w_accept");
    send_vec(mkvec(70), 1'b0);
    send_vec(mkvec(80), 1'b1);
    wait_idle();

    send_vec(mkvec(90), 1'b1);
    wait_idle();

    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 3) == 0) load_w(rndvec());
      len = $urandom_range(1, 5);
      for (int v = 0; v < len; v++) begin
        repeat ($urandom_range(0, 2)) idle_cycle();
        send_vec(rndvec(), v == len - 1);
      end
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    // Reset two cycles after the last accept of a frame, while draining.
    send_vec(mkvec(300), 1'b0);
    send_vec(mkvec(310), 1'b1);
    idle_cycle();
    cyc_drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, d_wa, d_sa);
    repeat (3) cyc_drive(1'b0, '0, 1'b1, mkvec(400), 1'b1, 1'b1, d_wa, d_sa);
    repeat (12) idle_cycle();

    load_w(rndvec());
    send_vec(rndvec(), 1'b0);
    send_vec(rndvec(), 1'b1);
    wait_idle();
    repeat (3) idle_cycle();

    tot = we_q.size() + done_q.size();
    for (int k = 0; k < NP; k++) tot += lane_q[k].size();
    chk("sb_empty", VW'(tot), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mpe_fmap_feeder.md
# mpe_fmap_feeder

Upstream feeder for one 9-PE processing column (`PE_fpu` chain).
- Accepts a weight vector and a stream of input-feature-map vectors over valid/ready handshakes.
- Drives the column's per-PE weight ports and `weight_en` pulse.
- Applies the diagonal skew so lane k reaches PE k exactly k·SKEW cycles after lane 0, and generates the per-PE `i_left_en`/`i_right_en` strobes.
- Sits directly between the fmap/weight buffer and the column.

## Interface

**Parameters**
- `DATA_WIDTH`, 32, width of one fp32 lane.
- `NUMBER_PE`, 9, PEs in the column (lanes).
- `SKEW`, 1, cycles of delay between adjacent lanes (≥1).

**Ports**
- `i_clk` in 1: single clock, rising edge.
- `i_rest_n` in 1: reset, synchronous, active-low.
- `w_valid` in 1: weight vector valid.
- `w_ready` out 1: weight vector accepted when `w_valid && w_ready`.
- `w_data` in NUMBER_PE·DATA_WIDTH: lane k at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `s_valid` in 1: fmap vector valid.
- `s_ready` out 1: fmap handshake.
- `s_data` in NUMBER_PE·DATA_WIDTH: fmap vector, same packing as `w_data`.
- `s_last` in 1: marks the final vector of a frame.
- `weight_out` out NUMBER_PE·DATA_WIDTH: to `weight_f_top` k.
- `weight_en` out 1: one-cycle weight load strobe.
- `fmap_out` out NUMBER_PE·DATA_WIDTH: to `i_fmap_f_left` k.
- `left_en` out NUMBER_PE: to `i_left_en` k.
- `right_en` out NUMBER_PE: to `i_right_en` k.
- `busy` out 1: high in LOAD_W/STREAM/DRAIN.
- `done` out 1: one-cycle frame-complete pulse.

## Operation

**FSM states:** IDLE, LOAD_W, STREAM, DRAIN.

**IDLE**
- `w_ready`=1.
- `s_ready` = `wt_loaded && !w_valid`.
- Weight accept → latch `w_data` into `weight_out`, set `wt_loaded`, go to LOAD_W.
- Fmap accept (weights reused) → enter the vector into the skew pipe, go to STREAM, or to DRAIN if `s_last`.
- `w_valid` has priority over `s_valid` in the same cycle.

**LOAD_W**
- `weight_en`=1 for this single cycle.
- `w_ready`=0, `s_ready`=0.
- Next state: STREAM.

**STREAM**
- `s_ready`=1, `w_ready`=0.
- Each accepted vector enters the skew pipe.
- A cycle without an accept inserts a bubble (no enable for that slot).
- Accepting with `s_last`=1 goes to DRAIN.

**DRAIN**
- `s_ready`=0, `w_ready`=0.
- Counter runs until the last vector's lane NUMBER_PE-1 has been emitted.
- Then `done`=1 for one cycle and return to IDLE.

**Skew pipe**
- Lane k is a k·SKEW-stage delay line of {valid, data} after a common input register.
- `left_en[k]` = delayed valid of lane k; `right_en[k]` = `left_en[k]`, same cycle.
- `fmap_out` lane k updates only when its delayed valid is 1; it holds its value during bubbles.
- `weight_out` holds until the next weight accept.

**Reset**
- Synchronous, takes effect at the clock edge where `i_rest_n`=0.
- Clears state to IDLE, `wt_loaded`, all delay lines, `weight_out`, `fmap_out`, `left_en`, `right_en`, `weight_en`, `done` and `busy` (all 0).
- `w_ready`=1 and `s_ready`=0 during and after reset.
- Reset mid-frame discards in-flight vectors; no enable is asserted after the reset edge.

## Timing

- Weight accepted at edge t → `weight_en`=1 in cycle t+1 → `s_ready`=1 from cycle t+2.
- Fmap accepted at edge t → `left_en[k]`/`right_en[k]`=1 with lane k data in cycle t+1+k·SKEW.
- Throughput: one vector per cycle in STREAM, with no stall from the column.
- Last vector accepted at t_L:
  - final enable (lane NUMBER_PE-1) is in cycle t_L+1+(NUMBER_PE-1)·SKEW;
  - `done`=1 in the following cycle, with state IDLE from the next cycle.
- Minimum frame is one vector with `s_last`=1 (straight IDLE→DRAIN when `wt_loaded`).
- Vectors on the lane-0 enable are never dropped or duplicated. Per lane, the count of `left_en` pulses equals the number of accepted vectors.

## Test plan

All scenarios use N=9 and SKEW=1.

1. **Reset state:** hold `i_rest_n`=0 for 2 cycles → all outputs 0, `w_ready`=1, `s_ready`=0. An `s_valid` before any weight load is not accepted.
2. **Weight load:** `w_data` lane k = k+1.0 accepted at t → `weight_en`=1 only in t+1, `weight_out` lanes = 1.0…9.0, `s_ready`=1 at t+2.
3. **Three-vector frame, back-to-back:**
   - Stimulus: vectors V0..V2 with lane k = 10·v+k, `s_last` on V2, accepted at t..t+2.
   - Lane k sees V0,V1,V2 in cycles t+1+k..t+3+k.
   - `left_en[8]` high in t+9..t+11, `done` at t+12.
4. **Bubble:** V0 accepted at t, no accept at t+1, V1 accepted at t+2 → `left_en[4]` pattern 1,0,1 in t+5..t+7, and `fmap_out` lane 4 holds V0 through t+6.
5. **Simultaneous valid in IDLE with `wt_loaded`:** `w_valid`=`s_valid`=1 → weight accepted, fmap not accepted (`s_ready`=0), `weight_en` next cycle.
6. **Reset mid-DRAIN:** assert `i_rest_n`=0 two cycles after the last accept → all enables 0 from the following cycle, no `done`, state IDLE.
